// File: rtl/fp_adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
// Ports:
//   a, b : operands
//   s    : a + b
// NaN inputs or Inf - Inf give the quiet NaN 7FC00000. Denormal inputs and results are
// supported. Exact cancellation gives +0.
module fp_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] s
);

  logic        a_nan, b_nan, a_inf, b_inf;
  logic [31:0] xv, yv;
  logic        sx, sy;
  logic [7:0]  ex, ey, d;
  logic [23:0] mx, my;
  logic [27:0] wx, wy, w;
  logic [9:0]  e;
  logic [24:0] mr;
  logic        g, rs;

  assign a_nan = (&a[30:23]) & (|a[22:0]);
  assign b_nan = (&b[30:23]) & (|b[22:0]);
  assign a_inf = (&a[30:23]) & ~(|a[22:0]);
  assign b_inf = (&b[30:23]) & ~(|b[22:0]);

  always_comb begin
    s  = '0;
    // x carries the larger magnitude so the difference below is never negative
    xv = (a[30:0] >= b[30:0]) ? a : b;
    yv = (a[30:0] >= b[30:0]) ? b : a;
    sx = xv[31];
    sy = yv[31];
    // denormals share the exponent of the smallest normal
    ex = (xv[30:23] == 8'd0) ? 8'd1 : xv[30:23];
    ey = (yv[30:23] == 8'd0) ? 8'd1 : yv[30:23];
    mx = {|xv[30:23], xv[22:0]};
    my = {|yv[30:23], yv[22:0]};
    d  = ex - ey;

    // three low bits are guard, round and sticky
    wx = {1'b0, mx, 3'b000};
    if (d >= 8'd27) begin
      wy = {27'd0, |my};
    end else begin
      wy    = {1'b0, my, 3'b000} >> d;
      wy[0] = wy[0] | (|({1'b0, my, 3'b000} & ~({28{1'b1}} << d)));
    end

    e = {2'b00, ex};
    if (sx == sy) begin
      w = wx + wy;
      if (w[27]) begin
        w = {1'b0, w[27:2], w[1] | w[0]};
        e = e + 10'd1;
      end
    end else begin
      w = wx - wy;
      // normalize left, stopping at the denormal exponent
      for (int i = 0; i < 26; i++) begin
        if (!w[26] && (e > 10'd1)) begin
          w = w << 1;
          e = e - 10'd1;
        end
      end
    end

    g  = w[2];
    rs = w[1] | w[0];
    mr = {1'b0, w[26:3]} + {24'd0, g & (rs | w[3])};
    if (mr[24]) begin
      mr = {1'b0, mr[24:1]};
      e  = e + 10'd1;
    end

    if (a_nan | b_nan | (a_inf & b_inf & (a[31] ^ b[31]))) begin
      s = 32'h7FC0_0000;
    end else if (a_inf) begin
      s = a;
    end else if (b_inf) begin
      s = b;
    end else if (w == 28'd0) begin
      s = {sx & sy, 31'd0};
    end else if (e >= 10'd255) begin
      s = {sx, 8'hFF, 23'd0};
    end else begin
      // a result without the hidden bit is denormal
      s = {sx, (mr[23] ? e[7:0] : 8'd0), mr[22:0]};
    end
  end

endmodule

// File: rtl/fp_accumulator.sv
// Streams single-precision operands through one fp_adder and reduces each in_last-delimited
// vector to one sum, presented on a valid/ready output with its element count.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   in_valid/in_ready/in_data      : operand stream
//   in_sub                         : negate operand (bit 31 flipped) before adding
//   in_last                        : operand closes the vector
//   out_valid/out_ready            : result handshake
//   out_data, out_count            : vector sum and element count (count saturates)
//   out_exc (FP_ACC_EXC_EN only)   : {inf_seen, nan_seen}, sticky over the vector
// Optional feature macro: FP_ACC_EXC_EN.
module fp_accumulator #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_sub,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [CNT_W-1:0] out_count
`ifdef FP_ACC_EXC_EN
  ,
  output logic [1:0]       out_exc
`endif
);

  typedef enum logic [0:0] {StAcc, StOut} state_e;

  state_e           state_q, state_d;
  logic [31:0]      acc_q, acc_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;

  logic [31:0]      op, sum, acc_new;
  logic [CNT_W-1:0] cnt_new;
  logic             accept;

  assign op      = in_data ^ {in_sub, 31'b0};
  assign accept  = (state_q == StAcc) && in_valid;
  // first element is taken verbatim so a lone -0.0 is not turned into +0.0
  assign acc_new = first_q ? op : sum;
  assign cnt_new = first_q ? CNT_W'(1) :
                   ((count_q == {CNT_W{1'b1}}) ? count_q : count_q + CNT_W'(1));

  fp_adder u_fp_adder (
    .a (acc_q),
    .b (op),
    .s (sum)
  );

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    first_d     = first_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    case (state_q)
      StAcc: begin
        if (in_valid) begin
          if (in_last) begin
            out_data_d  = acc_new;
            out_count_d = cnt_new;
            out_valid_d = 1'b1;
            state_d     = StOut;
            first_d     = 1'b1;
            count_d     = '0;
            acc_d       = '0;
          end else begin
            acc_d   = acc_new;
            count_d = cnt_new;
            first_d = 1'b0;
          end
        end
      end
      StOut: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StAcc;
        end
      end
      default: state_d = StAcc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StAcc;
      acc_q       <= '0;
      first_q     <= 1'b1;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      first_q     <= first_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
    end
  end

  assign in_ready  = (state_q == StAcc);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_count = out_count_q;

`ifdef FP_ACC_EXC_EN
  // flags are {inf, nan}
  logic [1:0] sticky_q, sticky_d;
  logic [1:0] exc_q, exc_d;
  logic [1:0] exc_now;

  function automatic logic [1:0] classify(input logic [31:0] v);
    return {(&v[30:23]) & ~(|v[22:0]), (&v[30:23]) & (|v[22:0])};
  endfunction

  assign exc_now = sticky_q | classify(op) | classify(acc_new);

  always_comb begin
    sticky_d = sticky_q;
    exc_d    = exc_q;
    if (accept) begin
      if (in_last) begin
        exc_d    = exc_now;
        sticky_d = 2'b00;
      end else begin
        sticky_d = exc_now;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= 2'b00;
      exc_q    <= 2'b00;
    end else begin
      sticky_q <= sticky_d;
      exc_q    <= exc_d;
    end
  end

  assign out_exc = exc_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

endmodule
